vi_window: RTL and testbench

- Video pipeline stage between char_gen and vo, in the vo_clk domain.
- Tracks the pixel position of the incoming stream and overlays one rectangular window with a solid border and fill. This is the base primitive for status boxes behind the text console.
- Window registers are static inputs, shadowed at frame start so an update never tears.
- The stream passes through with a fixed 2-cycle latency.

---
 rtl/vi_pkg.sv | 31 +++
 rtl/vi_pos_cntr.sv | 54 +++++
 rtl/vi_window.sv | 156 +++++++++++++++
 tb/tb_vi_window.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vi_pkg.sv
// Shared types and helpers for the vi_* video pipeline stages.
// Stream bundle travels between stages; blend helper serves the optional fill blend.
package vi_pkg;

    localparam int PIXEL_W = 24;
    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

    typedef struct packed {
        logic               vsync;
        logic               req;
        logic               eol;
        logic               eof;
        logic [PIXEL_W-1:0] pixel;
    } vi_stream_t;

    // Halving both operands first keeps each channel sum within 8 bits, so no carry crosses channels.
    function automatic logic [PIXEL_W-1:0] vi_blend50(input logic [PIXEL_W-1:0] a,
                                                      input logic [PIXEL_W-1:0] b);
        logic [PIXEL_W-1:0] r;
        r[R_HI:R_LO] = {1'b0, a[R_HI:R_LO+1]} + {1'b0, b[R_HI:R_LO+1]};
        r[G_HI:G_LO] = {1'b0, a[G_HI:G_LO+1]} + {1'b0, b[G_HI:G_LO+1]};
        r[B_HI:B_LO] = {1'b0, a[B_HI:B_LO+1]} + {1'b0, b[B_HI:B_LO+1]};
        return r;
    endfunction

endpackage

// File: rtl/vi_pos_cntr.sv
// Pixel position tracker: x/y of the pixel presented this cycle plus a synced flag.
// x_o/y_o/synced_o already account for a vsync in the same cycle.
module vi_pos_cntr #(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vsync_i,
    input  logic              req_i,
    input  logic              eol_i,
    input  logic              eof_i,
    output logic [H_BITS-1:0] x_o,
    output logic [V_BITS-1:0] y_o,
    output logic              synced_o
);

    logic [H_BITS-1:0] x_q, x_d;
    logic [V_BITS-1:0] y_q, y_d;
    logic              synced_q, synced_d;

    always_comb begin
        x_o      = vsync_i ? '0 : x_q;
        y_o      = vsync_i ? '0 : y_q;
        synced_o = vsync_i | synced_q;
        x_d      = x_o;
        y_d      = y_o;
        synced_d = synced_o;
        if (req_i) begin
            if (eof_i) begin
                x_d = '0;
                y_d = '0;
            end else if (eol_i) begin
                x_d = '0;
                y_d = y_o + 1'b1;
            end else begin
                x_d = x_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q      <= '0;
            y_q      <= '0;
            synced_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            synced_q <= synced_d;
        end
    end

endmodule

// File: rtl/vi_window.sv
// Rectangular window overlay (border + fill) on the video stream, fixed 2-cycle latency.
// Optional VI_WINDOW_BLEND_EN: fill becomes a 50% blend with the incoming pixel.
module vi_window
    import vi_pkg::*;
#(
    parameter int H_BITS   = 12,
    parameter int V_BITS   = 12,
    parameter int BORDER_W = 2
) (
    input  logic                vo_clk,
    input  logic                vo_reset,
    input  logic                win_enable,
    input  logic [H_BITS-1:0]   win_x0,
    input  logic [H_BITS-1:0]   win_x1,
    input  logic [V_BITS-1:0]   win_y0,
    input  logic [V_BITS-1:0]   win_y1,
    input  logic [PIXEL_W-1:0]  win_border_color,
    input  logic [PIXEL_W-1:0]  win_fill_color,
    input  logic                in_vsync,
    input  logic                in_req,
    input  logic                in_eol,
    input  logic                in_eof,
    input  logic [PIXEL_W-1:0]  in_pixel,
    output logic                out_vsync,
    output logic                out_req,
    output logic                out_eol,
    output logic                out_eof,
    output logic [PIXEL_W-1:0]  out_pixel
);

    localparam logic [H_BITS-1:0] BW_H = H_BITS'(BORDER_W);
    localparam logic [V_BITS-1:0] BW_V = V_BITS'(BORDER_W);

    logic [H_BITS-1:0] pos_x;
    logic [V_BITS-1:0] pos_y;
    logic              pos_synced;

    vi_pos_cntr #(.H_BITS(H_BITS), .V_BITS(V_BITS)) u_pos (
        .clk_i    (vo_clk),
        .rst_i    (vo_reset),
        .vsync_i  (in_vsync),
        .req_i    (in_req),
        .eol_i    (in_eol),
        .eof_i    (in_eof),
        .x_o      (pos_x),
        .y_o      (pos_y),
        .synced_o (pos_synced)
    );

    logic               sh_en_q;
    logic [H_BITS-1:0]  sh_x0_q, sh_x1_q;
    logic [V_BITS-1:0]  sh_y0_q, sh_y1_q;
    logic [PIXEL_W-1:0] sh_border_q, sh_fill_q;

    always_ff @(posedge vo_clk) begin
        if (vo_reset) begin
            sh_en_q     <= 1'b0;
            sh_x0_q     <= '0;
            sh_x1_q     <= '0;
            sh_y0_q     <= '0;
            sh_y1_q     <= '0;
            sh_border_q <= '0;
            sh_fill_q   <= '0;
        end else if (in_vsync) begin
            sh_en_q     <= win_enable;
            sh_x0_q     <= win_x0;
            sh_x1_q     <= win_x1;
            sh_y0_q     <= win_y0;
            sh_y1_q     <= win_y1;
            sh_border_q <= win_border_color;
            sh_fill_q   <= win_fill_color;
        end
    end

    // A vsync pixel is classified against the values being shadowed in that same cycle.
    logic               cur_en;
    logic [H_BITS-1:0]  cur_x0, cur_x1;
    logic [V_BITS-1:0]  cur_y0, cur_y1;
    logic [PIXEL_W-1:0] cur_border, cur_fill;

    always_comb begin
        cur_en     = in_vsync ? win_enable       : sh_en_q;
        cur_x0     = in_vsync ? win_x0           : sh_x0_q;
        cur_x1     = in_vsync ? win_x1           : sh_x1_q;
        cur_y0     = in_vsync ? win_y0           : sh_y0_q;
        cur_y1     = in_vsync ? win_y1           : sh_y1_q;
        cur_border = in_vsync ? win_border_color : sh_border_q;
        cur_fill   = in_vsync ? win_fill_color   : sh_fill_q;
    end

    logic               in_x, in_y, edge_hit;
    logic               inside_d, border_d;
    logic [PIXEL_W-1:0] color_d;

    // Subtractions may wrap outside the window; they only matter once inside_d holds.
    always_comb begin
        in_x     = (pos_x >= cur_x0) && (pos_x <= cur_x1);
        in_y     = (pos_y >= cur_y0) && (pos_y <= cur_y1);
        inside_d = in_req & cur_en & pos_synced & in_x & in_y;
        edge_hit = ((pos_x - cur_x0) < BW_H) | ((cur_x1 - pos_x) < BW_H) |
                   ((pos_y - cur_y0) < BW_V) | ((cur_y1 - pos_y) < BW_V);
        border_d = inside_d & edge_hit;
        color_d  = border_d ? cur_border : cur_fill;
    end

    vi_stream_t         s1_q;
    logic               inside_q, border_q;
    logic [PIXEL_W-1:0] color_q;

    always_ff @(posedge vo_clk) begin
        if (vo_reset) begin
            s1_q     <= '0;
            inside_q <= 1'b0;
            border_q <= 1'b0;
            color_q  <= '0;
        end else begin
            s1_q     <= '{vsync: in_vsync, req: in_req, eol: in_eol, eof: in_eof, pixel: in_pixel};
            inside_q <= inside_d;
            border_q <= border_d;
            color_q  <= color_d;
        end
    end

    logic [PIXEL_W-1:0] fill_px, px_d;

    always_comb begin
`ifdef VI_WINDOW_BLEND_EN
        fill_px = vi_blend50(s1_q.pixel, color_q);
`else
        fill_px = color_q;
`endif
        px_d = s1_q.pixel;
        if (border_q)
            px_d = color_q;
        else if (inside_q)
            px_d = fill_px;
    end

    vi_stream_t out_q;

    always_ff @(posedge vo_clk) begin
        if (vo_reset) begin
            out_q <= '0;
        end else begin
            out_q       <= s1_q;
            out_q.pixel <= px_d;
        end
    end

    assign out_vsync = out_q.vsync;
    assign out_req   = out_q.req;
    assign out_eol   = out_q.eol;
    assign out_eof   = out_q.eof;
    assign out_pixel = out_q.pixel;

endmodule

// File: tb/tb_vi_window.sv
// Scoreboard bench for vi_window: a reference model pushes expected output per input cycle,
// popped two cycles later; per-test spot checks read back captured output images.
module tb_vi_window;

    localparam int BW = 2;

    logic        vo_clk = 1'b0;
    logic        vo_reset, win_enable;
    logic [11:0] win_x0, win_x1, win_y0, win_y1;
    logic [23:0] win_border_color, win_fill_color;
    logic        in_vsync, in_req, in_eol, in_eof;
    logic [23:0] in_pixel;
    logic        out_vsync, out_req, out_eol, out_eof;
    logic [23:0] out_pixel;

    int checks = 0;
    int errors = 0;

    always #5 vo_clk = ~vo_clk;

    vi_window #(.H_BITS(12), .V_BITS(12), .BORDER_W(BW)) dut (
        .vo_clk(vo_clk), .vo_reset(vo_reset), .win_enable(win_enable),
        .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
        .win_border_color(win_border_color), .win_fill_color(win_fill_color),
        .in_vsync(in_vsync), .in_req(in_req), .in_eol(in_eol), .in_eof(in_eof),
        .in_pixel(in_pixel),
        .out_vsync(out_vsync), .out_req(out_req), .out_eol(out_eol), .out_eof(out_eof),
        .out_pixel(out_pixel)
    );

    typedef struct {
        bit          vs, rq, eol, eof;
        logic [23:0] px;
        int          x, y;
    } exp_t;

    exp_t q[$];

    // reference model state
    int          mx, my, mx0, mx1, my0, my1;
    bit          msync, men;
    logic [23:0] mb, mf;

    logic [23:0] oimg [0:15][0:31];
    logic [23:0] iimg [0:15][0:31];

    function automatic logic [23:0] fill_exp(input logic [23:0] p, input logic [23:0] f);
`ifdef VI_WINDOW_BLEND_EN
        logic [23:0] r;
        r[23:16] = (p[23:16] >> 1) + (f[23:16] >> 1);
        r[15:8]  = (p[15:8]  >> 1) + (f[15:8]  >> 1);
        r[7:0]   = (p[7:0]   >> 1) + (f[7:0]   >> 1);
        return r;
`else
        return f;
`endif
    endfunction

    task automatic clear_img();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 32; x++) begin
                oimg[y][x] = 'x;
                iimg[y][x] = 'x;
            end
    endtask

    // One input cycle: model it, push expectation, clock, compare the entry two cycles old.
    task automatic cyc(input bit rst, input bit vs, input bit rq, input bit eol, input bit eof,
                       input logic [23:0] px);
        exp_t e, z;
        bit ins, brd;
        vo_reset = rst; in_vsync = vs; in_req = rq; in_eol = eol; in_eof = eof; in_pixel = px;
        if (rst) begin
            z = '{vs: 0, rq: 0, eol: 0, eof: 0, px: 24'h0, x: -1, y: -1};
            q.delete();
            q.push_back(z);
            q.push_back(z);
            mx = 0; my = 0; msync = 0; men = 0;
            mx0 = 0; mx1 = 0; my0 = 0; my1 = 0; mb = 0; mf = 0;
        end else begin
            if (vs) begin
                mx = 0; my = 0; msync = 1;
                men = win_enable; mx0 = int'(win_x0); mx1 = int'(win_x1);
                my0 = int'(win_y0); my1 = int'(win_y1);
                mb = win_border_color; mf = win_fill_color;
            end
            ins = rq && men && msync && mx >= mx0 && mx <= mx1 && my >= my0 && my <= my1;
            brd = ins && ((mx - mx0 < BW) || (mx1 - mx < BW) || (my - my0 < BW) || (my1 - my < BW));
            e.vs = vs; e.rq = rq; e.eol = eol; e.eof = eof; e.x = mx; e.y = my;
            e.px = brd ? mb : (ins ? fill_exp(px, mf) : px);
            if (rq && mx < 32 && my < 16) iimg[my][mx] = px;
            q.push_back(e);
            if (rq) begin
                if (eof) begin mx = 0; my = 0; end
                else if (eol) begin mx = 0; my = (my + 1) % 4096; end
                else mx = (mx + 1) % 4096;
            end
        end
        @(posedge vo_clk);
        #1;
        if (q.size() == 2) begin
            e = q.pop_front();
            checks++;
            if ({out_vsync, out_req, out_eol, out_eof, out_pixel} !== {e.vs, e.rq, e.eol, e.eof, e.px}) begin
                errors++;
                $display("FAIL stream x=%0d y=%0d got v%b r%b l%b f%b %h exp v%b r%b l%b f%b %h",
                         e.x, e.y, out_vsync, out_req, out_eol, out_eof, out_pixel,
                         e.vs, e.rq, e.eol, e.eof, e.px);
            end
            if (e.rq && e.x >= 0 && e.x < 32 && e.y >= 0 && e.y < 16) oimg[e.y][e.x] = out_pixel;
        end
    endtask

    task automatic send_frame(input int w, input int h, input bit gaps, input bit rnd,
                              input logic [23:0] base, input bit vs_first,
                              input int chg_line, input int rst_line);
        logic [23:0] px;
        clear_img();
        if (!vs_first) cyc(0, 1, 0, 0, 0, base);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                if (y == chg_line && x == 0) win_x0 = 12'd0;
                if (y == rst_line && x == 0) repeat (3) cyc(1, 0, 0, 0, 0, 24'h0);
                if (gaps && $urandom_range(0, 2) == 0) cyc(0, 0, 0, 0, 0, 24'($urandom));
                px = rnd ? 24'($urandom) : base;
                cyc(0, vs_first && x == 0 && y == 0, 1, x == w - 1, (x == w - 1) && (y == h - 1), px);
            end
        cyc(0, 0, 0, 0, 0, 24'h0);
        cyc(0, 0, 0, 0, 0, 24'h0);
    endtask

    task automatic set_win(input int x0, input int x1, input int y0, input int y1);
        win_enable = 1'b1;
        win_x0 = 12'(x0); win_x1 = 12'(x1); win_y0 = 12'(y0); win_y1 = 12'(y1);
        win_border_color = 24'hFF0000;
        win_fill_color   = 24'h00FF00;
    endtask

    task automatic test_reset();
        repeat (3) cyc(1, 0, 0, 0, 0, 24'h0);
        checks++;
        if ({out_vsync, out_req, out_eol, out_eof, out_pixel} !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {out_vsync, out_req, out_eol, out_eof, out_pixel});
        end
        checks++;
        if (dut.u_pos.synced_q !== 1'b0 || dut.u_pos.x_q !== 12'h0 || dut.u_pos.y_q !== 12'h0) begin
            errors++;
            $display("FAIL reset_counters got synced=%b x=%0d y=%0d exp 0 0 0",
                     dut.u_pos.synced_q, dut.u_pos.x_q, dut.u_pos.y_q);
        end
    endtask

    task automatic test_basic();
        set_win(10, 19, 5, 8);
        send_frame(32, 12, 0, 0, 24'h000080, 0, -1, -1);
        checks++;
        if (oimg[5][10] !== 24'hFF0000) begin errors++; $display("FAIL basic_corner got %h exp ff0000", oimg[5][10]); end
        // window only 4 lines tall with border 2: every line of it is border
        checks++;
        if (oimg[7][12] !== 24'hFF0000) begin errors++; $display("FAIL basic_12_7 got %h exp ff0000", oimg[7][12]); end
        checks++;
        if (oimg[5][20] !== 24'h000080) begin errors++; $display("FAIL basic_outside got %h exp 000080", oimg[5][20]); end
        set_win(10, 19, 3, 9);
        send_frame(32, 12, 0, 0, 24'h000080, 0, -1, -1);
        checks++;
        if (oimg[6][12] !== fill_exp(24'h000080, 24'h00FF00)) begin
            errors++; $display("FAIL basic_fill got %h exp %h", oimg[6][12], fill_exp(24'h000080, 24'h00FF00));
        end
        checks++;
        if (oimg[6][11] !== 24'hFF0000) begin errors++; $display("FAIL basic_left_border got %h exp ff0000", oimg[6][11]); end
    endtask

    task automatic test_midframe_change();
        set_win(10, 19, 5, 8);
        send_frame(32, 12, 0, 0, 24'h000080, 0, 6, -1);
        checks++;
        if (oimg[7][0] !== 24'h000080) begin errors++; $display("FAIL mid_same_frame got %h exp 000080", oimg[7][0]); end
        send_frame(32, 12, 0, 0, 24'h000080, 0, -1, -1);
        checks++;
        if (oimg[5][0] !== 24'hFF0000) begin errors++; $display("FAIL mid_next_frame got %h exp ff0000", oimg[5][0]); end
    endtask

    task automatic test_reset_midframe();
        set_win(10, 19, 5, 8);
        send_frame(32, 12, 0, 0, 24'h000080, 0, -1, 4);
        // after the reset the counters restart at 0 but no overlay may appear
        checks++;
        if (oimg[5][10] !== 24'h000080) begin errors++; $display("FAIL rst_no_overlay got %h exp 000080", oimg[5][10]); end
        send_frame(32, 12, 0, 0, 24'h000080, 0, -1, -1);
        checks++;
        if (oimg[5][10] !== 24'hFF0000) begin errors++; $display("FAIL rst_next_frame got %h exp ff0000", oimg[5][10]); end
    endtask

    task automatic test_empty_and_small();
        int bad;
        set_win(8, 3, 2, 9);
        send_frame(32, 12, 0, 1, 24'h0, 0, -1, -1);
        bad = 0;
        for (int y = 0; y < 12; y++)
            for (int x = 0; x < 32; x++)
                if (oimg[y][x] !== iimg[y][x]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL empty_window got %0d altered pixels exp 0", bad); end
        set_win(4, 6, 2, 4);
        send_frame(16, 8, 0, 1, 24'h0, 0, -1, -1);
        bad = 0;
        for (int y = 2; y <= 4; y++)
            for (int x = 4; x <= 6; x++)
                if (oimg[y][x] !== 24'hFF0000) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL small_all_border got %0d non-border exp 0", bad); end
    endtask

    task automatic test_gaps();
        set_win(10, 19, 3, 9);
        send_frame(32, 12, 1, 0, 24'h000080, 0, -1, -1);
        checks++;
        if (oimg[3][10] !== 24'hFF0000) begin errors++; $display("FAIL gaps_corner got %h exp ff0000", oimg[3][10]); end
        checks++;
        if (oimg[6][12] !== fill_exp(24'h000080, 24'h00FF00)) begin
            errors++; $display("FAIL gaps_fill got %h exp %h", oimg[6][12], fill_exp(24'h000080, 24'h00FF00));
        end
        checks++;
        if (oimg[6][20] !== 24'h000080) begin errors++; $display("FAIL gaps_outside got %h exp 000080", oimg[6][20]); end
    endtask

    task automatic test_back_to_back();
        set_win(0, 5, 0, 5);
        send_frame(8, 6, 0, 1, 24'h0, 1, -1, -1);
        checks++;
        if (oimg[0][0] !== 24'hFF0000) begin errors++; $display("FAIL b2b_vsync_pixel got %h exp ff0000", oimg[0][0]); end
        win_border_color = 24'h0000FF;
        send_frame(8, 6, 0, 1, 24'h0, 1, -1, -1);
        checks++;
        if (oimg[0][0] !== 24'h0000FF) begin errors++; $display("FAIL b2b_shadow_same_cycle got %h exp 0000ff", oimg[0][0]); end
    endtask

`ifdef VI_WINDOW_BLEND_EN
    task automatic test_blend();
        set_win(2, 9, 1, 7);
        win_fill_color = 24'h20FF00;
        send_frame(12, 9, 0, 0, 24'h804020, 0, -1, -1);
        checks++;
        if (oimg[4][5] !== 24'h509F10) begin errors++; $display("FAIL blend_fill got %h exp 509f10", oimg[4][5]); end
        checks++;
        if (oimg[1][2] !== 24'hFF0000) begin errors++; $display("FAIL blend_border got %h exp ff0000", oimg[1][2]); end
    endtask
`endif

    initial begin
        vo_reset = 1'b1; in_vsync = 0; in_req = 0; in_eol = 0; in_eof = 0; in_pixel = 0;
        set_win(0, 0, 0, 0);
        win_enable = 1'b0;
        test_reset();
        test_basic();
        test_midframe_change();
        test_reset_midframe();
        test_empty_and_small();
        test_gaps();
        test_back_to_back();
`ifdef VI_WINDOW_BLEND_EN
        test_blend();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
